seq_barrel_multiplier: RTL

//  Parametrised sequential shift-add multiplier; next generation of our 8-bit combinational barrel multiplier.

---
 rtl/seq_barrel_multiplier.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_barrel_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, K multiplier bits per cycle.
// Signed operands are reduced to magnitudes on accept. The product sign is applied once, in FIX.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | in_ready high, waiting for in_valid
// S_CALC | add K partial products per cycle into the accumulator
// S_FIX  | apply the product sign and load p
// S_DONE | out_valid high, hold p until out_ready
module seq_barrel_multiplier #(
  parameter int WIDTH      = 8,
  parameter int K          = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] LP_W = SW'(WIDTH);
  localparam logic [SW-1:0] LP_K = SW'(K);

  generate
    if ((K < 1) || (WIDTH < 2) || ((WIDTH % K) != 0)) begin : g_bad_param
      $error("seq_barrel_multiplier: WIDTH must be >= 2 and a multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ma;
  logic [WIDTH-1:0]  r_mb;
  logic [PW-1:0]     r_acc;
  logic [SW-1:0]     r_shift;
  logic              r_neg;
  logic [PW-1:0]     r_p;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              r_busy;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic [PW-1:0]     w_pp;
  logic [WIDTH-1:0]  w_mb_nxt;
  logic [SW-1:0]     w_shift_nxt;
  logic              w_calc_end;

  // Magnitudes of the operands; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
  end

  // Sum of the K partial products for this cycle; r_ma is already pre-shifted by the bits consumed so far.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < K; i++) begin
      if (r_mb[i]) w_pp = w_pp + (r_ma << i);
    end
  end

  // Loop bookkeeping and exit decision for CALC.
  always_comb begin
    w_mb_nxt    = r_mb >> K;
    w_shift_nxt = r_shift + LP_K;
    w_calc_end  = (w_shift_nxt == LP_W) || ((EARLY_EXIT != 0) && (w_mb_nxt == '0));
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_shift     <= '0;
      r_neg       <= 1'b0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ma       <= {{WIDTH{1'b0}}, w_a_mag};
            r_mb       <= w_b_mag;
            r_neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc      <= '0;
            r_shift    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc   <= r_acc + w_pp;
          r_ma    <= r_ma << K;
          r_mb    <= w_mb_nxt;
          r_shift <= w_shift_nxt;
          if (w_calc_end) r_state <= S_FIX;
        end
        S_FIX: begin
          // Negating zero yields zero, so a zero product never picks up a sign.
          r_p         <= r_neg ? -r_acc : r_acc;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign busy      = r_busy;

endmodule
